// File: rtl/axis_crc_pkg.sv
// axis_crc_pkg: types, defaults and helpers shared by the CRC-path arbiter.
// The stats build is enabled with AXIS_CRC_ARB_STATS_EN.
package axis_crc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_t;

    localparam int DEFAULT_DATA_WIDTH = 512;
    localparam int DEFAULT_LEN_WIDTH  = 16;

    // popcount covers tkeep up to 256 bytes; callers zero-extend
    localparam int POP_MAX = 256;
    localparam int POP_W   = 9;

    function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < POP_MAX; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// axis_rr_pick: combinational round-robin picker.
// Scans req from ptr+1 upward, wrapping; first set bit wins.
module axis_rr_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt,
    output logic         found
);

    logic [W:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = {1'b0, ptr} + (W+1)'(i);
            if (idx >= (W+1)'(N)) begin
                idx = idx - (W+1)'(N);
            end
            if (!found && req[idx[W-1:0]]) begin
                found = 1'b1;
                gnt   = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_stream_crc_arbiter.sv
// axi_stream_crc_arbiter: packet-locked round-robin AXI-Stream mux with
// registered output and optional byte-count stats (AXIS_CRC_ARB_STATS_EN).
module axi_stream_crc_arbiter
    import axis_crc_pkg::*;
#(
    parameter  int NUM_SRC    = 4,
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int KEEP_BYTES = DATA_WIDTH / 8,
    parameter  int LEN_WIDTH  = DEFAULT_LEN_WIDTH,
    localparam int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          srst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_s_tdata,
    input  logic [NUM_SRC*KEEP_BYTES-1:0] i_s_tkeep,
    input  logic [NUM_SRC-1:0]            i_s_tlast,
    input  logic [NUM_SRC-1:0]            i_s_tvalid,
    output logic [NUM_SRC-1:0]            o_s_tready,
    output logic [DATA_WIDTH-1:0]         o_m_tdata,
    output logic [KEEP_BYTES-1:0]         o_m_tkeep,
    output logic                          o_m_tlast,
    output logic [SRC_W-1:0]              o_m_tid,
    output logic                          o_m_tvalid,
    input  logic                          i_m_tready,
    output logic                          o_pkt_done,
    output logic [SRC_W-1:0]              o_pkt_src,
    output logic [LEN_WIDTH-1:0]          o_pkt_bytes
);

    arb_state_t            state;
    logic [SRC_W-1:0]      rr_ptr;
    logic [SRC_W-1:0]      gnt;
    logic [SRC_W-1:0]      pick;
    logic                  pick_found;
    logic                  out_ready;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_BYTES-1:0] sel_keep;
    logic                  sel_last;
    logic                  sel_valid;

    axis_rr_pick #(.N(NUM_SRC)) u_pick (
        .req   (i_s_tvalid),
        .ptr   (rr_ptr),
        .gnt   (pick),
        .found (pick_found)
    );

    assign sel_data  = i_s_tdata[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_keep  = i_s_tkeep[int'(gnt)*KEEP_BYTES +: KEEP_BYTES];
    assign sel_last  = i_s_tlast[gnt];
    assign sel_valid = i_s_tvalid[gnt];
    assign out_ready = !o_m_tvalid || i_m_tready;

    // no handshake is offered while reset is being sampled
    assign accept = srst_n && (state == PASS) && sel_valid && out_ready;

    always_comb begin
        o_s_tready = '0;
        if (srst_n && state == PASS) begin
            o_s_tready[gnt] = out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state      <= IDLE;
            rr_ptr     <= SRC_W'(NUM_SRC - 1);
            gnt        <= '0;
            o_m_tvalid <= 1'b0;
            o_m_tlast  <= 1'b0;
            o_m_tdata  <= '0;
            o_m_tkeep  <= '0;
            o_m_tid    <= '0;
        end else begin
            if (accept) begin
                o_m_tvalid <= 1'b1;
                o_m_tdata  <= sel_data;
                o_m_tkeep  <= sel_keep;
                o_m_tlast  <= sel_last;
                o_m_tid    <= gnt;
            end else if (i_m_tready) begin
                o_m_tvalid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt   <= pick;
                        state <= PASS;
                    end
                end
                PASS: begin
                    if (accept && sel_last) begin
                        rr_ptr <= gnt;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef AXIS_CRC_ARB_STATS_EN
    localparam int SUM_W = LEN_WIDTH + POP_W;

    logic [LEN_WIDTH-1:0] acc;
    logic [LEN_WIDTH-1:0] acc_next;
    logic [POP_MAX-1:0]   keep_ext;
    logic [SUM_W-1:0]     sum;

    always_comb begin
        keep_ext = '0;
        keep_ext[KEEP_BYTES-1:0] = sel_keep;
        sum      = SUM_W'(acc) + SUM_W'(popcount(keep_ext));
        acc_next = (|sum[SUM_W-1:LEN_WIDTH]) ? '1 : sum[LEN_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            acc         <= '0;
            o_pkt_done  <= 1'b0;
            o_pkt_src   <= '0;
            o_pkt_bytes <= '0;
        end else begin
            o_pkt_done <= 1'b0;
            if (accept) begin
                if (sel_last) begin
                    acc         <= '0;
                    o_pkt_done  <= 1'b1;
                    o_pkt_src   <= gnt;
                    o_pkt_bytes <= acc_next;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end
`else
    assign o_pkt_done  = 1'b0;
    assign o_pkt_src   = '0;
    assign o_pkt_bytes = '0;
`endif

endmodule

// File: tb/tb_axi_stream_crc_arbiter.sv
// tb_axi_stream_crc_arbiter: scoreboard bench for the packet arbiter.
// Stats checks follow AXIS_CRC_ARB_STATS_EN.
module tb_axi_stream_crc_arbiter;

    localparam int NS = 4;
    localparam int DW = 512;
    localparam int KB = 64;
    localparam int LW = 12;
    localparam int SW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KB-1:0] keep;
        logic          last;
        logic [SW-1:0] tid;
    } beat_t;

    logic             clk = 1'b0;
    logic             srst_n = 1'b0;
    logic [NS*DW-1:0] i_s_tdata = '0;
    logic [NS*KB-1:0] i_s_tkeep = '0;
    logic [NS-1:0]    i_s_tlast = '0;
    logic [NS-1:0]    i_s_tvalid = '0;
    logic [NS-1:0]    o_s_tready;
    logic [DW-1:0]    o_m_tdata;
    logic [KB-1:0]    o_m_tkeep;
    logic             o_m_tlast;
    logic [SW-1:0]    o_m_tid;
    logic             o_m_tvalid;
    logic             i_m_tready = 1'b0;
    logic             o_pkt_done;
    logic [SW-1:0]    o_pkt_src;
    logic [LW-1:0]    o_pkt_bytes;

    axi_stream_crc_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .KEEP_BYTES(KB), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .srst_n(srst_n),
        .i_s_tdata(i_s_tdata), .i_s_tkeep(i_s_tkeep),
        .i_s_tlast(i_s_tlast), .i_s_tvalid(i_s_tvalid),
        .o_s_tready(o_s_tready),
        .o_m_tdata(o_m_tdata), .o_m_tkeep(o_m_tkeep),
        .o_m_tlast(o_m_tlast), .o_m_tid(o_m_tid),
        .o_m_tvalid(o_m_tvalid), .i_m_tready(i_m_tready),
        .o_pkt_done(o_pkt_done), .o_pkt_src(o_pkt_src),
        .o_pkt_bytes(o_pkt_bytes)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    done_total = 0;
    bit    rst_drv = 1'b1;
    bit    sink_rdy = 1'b1;
    bit    src_en [NS];
    beat_t src_q [NS][$];
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    acc_src[$];
    int    acc_cyc[$];
    int    done_src[$];
    int    done_bytes[$];
    int    done_cyc[$];

    function automatic beat_t mk_beat(logic [KB-1:0] keep, logic last);
        beat_t b;
        for (int k = 0; k < DW / 32; k++) b.data[k*32 +: 32] = $urandom();
        b.keep = keep;
        b.last = last;
        b.tid  = '0;
        return b;
    endfunction

    task automatic clear_logs();
        for (int s = 0; s < NS; s++) src_q[s].delete();
        exp_q.delete(); obs_q.delete();
        acc_src.delete(); acc_cyc.delete();
        done_src.delete(); done_bytes.delete(); done_cyc.delete();
    endtask

    // one clock: drive after the edge, record handshakes at the falling edge
    task automatic step();
        beat_t b;
        @(posedge clk);
        #1;
        cyc++;
        srst_n = rst_drv;
        i_m_tready = sink_rdy;
        for (int s = 0; s < NS; s++) begin
            if (src_en[s] && src_q[s].size() > 0) begin
                b = src_q[s][0];
                i_s_tvalid[s] = 1'b1;
                i_s_tdata[s*DW +: DW] = b.data;
                i_s_tkeep[s*KB +: KB] = b.keep;
                i_s_tlast[s] = b.last;
            end else begin
                i_s_tvalid[s] = 1'b0;
                i_s_tlast[s] = 1'b0;
            end
        end
        @(negedge clk);
        for (int s = 0; s < NS; s++) begin
            if (i_s_tvalid[s] && o_s_tready[s] === 1'b1) begin
                b = src_q[s].pop_front();
                b.tid = SW'(s);
                exp_q.push_back(b);
                acc_src.push_back(s);
                acc_cyc.push_back(cyc);
            end
        end
        if (o_m_tvalid === 1'b1 && i_m_tready) begin
            b.data = o_m_tdata; b.keep = o_m_tkeep;
            b.last = o_m_tlast; b.tid = o_m_tid;
            obs_q.push_back(b);
        end
        if (o_pkt_done === 1'b1) begin
            done_total++;
            done_src.push_back(int'(o_pkt_src));
            done_bytes.push_back(int'(o_pkt_bytes));
            done_cyc.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        for (int s = 0; s < NS; s++) src_en[s] = 1'b1;
        sink_rdy = 1'b1;
        step(); step();
        rst_drv = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (o_s_tready !== '0 || o_m_tvalid !== 1'b0 || o_m_tlast !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl tready=%b valid=%b last=%b want 0", o_s_tready, o_m_tvalid, o_m_tlast);
        end
        n_vec++;
        if (o_m_tdata !== '0 || o_m_tkeep !== '0 || o_m_tid !== '0) begin
            n_err++;
            $display("FAIL reset_data keep=%h tid=%0d want 0", o_m_tkeep, o_m_tid);
        end
        n_vec++;
        if (o_pkt_done !== 1'b0 || o_pkt_src !== '0 || o_pkt_bytes !== '0) begin
            n_err++;
            $display("FAIL reset_stats done=%b src=%0d bytes=%0d want 0", o_pkt_done, o_pkt_src, o_pkt_bytes);
        end
    endtask

    task automatic test_single_packet();
        int t0;
        beat_t ob, eb;
        do_reset();
        src_q[2].push_back(mk_beat('1, 1'b0));
        src_q[2].push_back(mk_beat('1, 1'b0));
        src_q[2].push_back(mk_beat(64'h0F, 1'b1));
        t0 = cyc + 1;
        for (int k = 0; k < 20 && obs_q.size() < 3; k++) step();
        n_vec++;
        if (obs_q.size() != 3 || acc_cyc.size() != 3) begin
            n_err++;
            $display("FAIL single_count got=%0d want 3", obs_q.size());
        end else begin
            n_vec++;
            if (acc_cyc[0] != t0 + 1) begin
                n_err++;
                $display("FAIL single_latency got=%0d want %0d", acc_cyc[0], t0 + 1);
            end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ob = obs_q.pop_front(); eb = exp_q.pop_front();
            n_vec++;
            if (ob !== eb || ob.tid !== 2'd2) begin
                n_err++;
                $display("FAIL single_beat tid=%0d/2 last=%b/%b keep=%h/%h", ob.tid, ob.last, eb.last, ob.keep, eb.keep);
            end
        end
`ifdef AXIS_CRC_ARB_STATS_EN
        n_vec++;
        if (done_src.size() != 1 || acc_cyc.size() != 3) begin
            n_err++;
            $display("FAIL single_done_count got=%0d want 1", done_src.size());
        end else if (done_src[0] != 2 || done_bytes[0] != 2*KB + 4 || done_cyc[0] != acc_cyc[2] + 1) begin
            n_err++;
            $display("FAIL single_stats src=%0d bytes=%0d cyc=%0d want 2 %0d %0d",
                     done_src[0], done_bytes[0], done_cyc[0], 2*KB + 4, acc_cyc[2] + 1);
        end
`else
        n_vec++;
        if (done_src.size() != 0) begin
            n_err++;
            $display("FAIL single_nostats_done got=%0d want 0", done_src.size());
        end
`endif
    endtask

    task automatic test_round_robin();
        logic [KB-1:0] pat [4];
        int t0, pk;
        beat_t ob, eb;
        pat[0] = '1; pat[1] = '0; pat[2] = 64'h5; pat[3] = 64'hF0F0;
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < NS; s++)
                src_q[s].push_back(mk_beat(pat[(s*3 + p) % 4], 1'b1));
        t0 = cyc + 1;
        for (int k = 0; k < 80 && obs_q.size() < 12; k++) begin
            step();
            n_vec++;
            if ($countones(o_s_tready) > 1) begin
                n_err++;
                $display("FAIL rr_onehot tready=%b want one-hot or zero", o_s_tready);
            end
        end
        n_vec++;
        if (acc_src.size() != 12) begin
            n_err++;
            $display("FAIL rr_count got=%0d want 12", acc_src.size());
        end else begin
            n_vec++;
            if (acc_cyc[0] != t0 + 1) begin
                n_err++;
                $display("FAIL rr_first got=%0d want %0d", acc_cyc[0], t0 + 1);
            end
            for (int i = 0; i < 12; i++) begin
                n_vec++;
                if (acc_src[i] != i % 4) begin
                    n_err++;
                    $display("FAIL rr_order idx=%0d got=%0d want %0d", i, acc_src[i], i % 4);
                end
                if (i > 0) begin
                    n_vec++;
                    if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
                        n_err++;
                        $display("FAIL rr_gap idx=%0d got=%0d want 2", i, acc_cyc[i] - acc_cyc[i-1]);
                    end
                end
            end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ob = obs_q.pop_front(); eb = exp_q.pop_front();
            n_vec++;
            if (ob !== eb) begin
                n_err++;
                $display("FAIL rr_beat tid=%0d/%0d keep=%h/%h", ob.tid, eb.tid, ob.keep, eb.keep);
            end
        end
`ifdef AXIS_CRC_ARB_STATS_EN
        n_vec++;
        if (done_src.size() != 12) begin
            n_err++;
            $display("FAIL rr_done_count got=%0d want 12", done_src.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                pk = $countones(pat[((i % 4)*3 + i / 4) % 4]);
                n_vec++;
                if (done_src[i] != i % 4 || done_bytes[i] != pk) begin
                    n_err++;
                    $display("FAIL rr_stats idx=%0d src=%0d bytes=%0d want %0d %0d",
                             i, done_src[i], done_bytes[i], i % 4, pk);
                end
            end
        end
`else
        n_vec++;
        if (done_src.size() != 0) begin
            n_err++;
            $display("FAIL rr_nostats_done got=%0d want 0", done_src.size());
        end
`endif
    endtask

    task automatic test_stall();
        bit hold;
        logic [DW+KB+1:0] held;
        int want [6];
        beat_t ob, eb;
        want = '{1, 1, 1, 1, 3, 3};
        do_reset();
        for (int i = 0; i < 4; i++)
            src_q[1].push_back(mk_beat(i == 3 ? 64'h3 : '1, i == 3));
        for (int i = 0; i < 2; i++)
            src_q[3].push_back(mk_beat('1, i == 1));
        hold = 1'b0;
        held = '0;
        for (int j = 0; j < 40 && obs_q.size() < 6; j++) begin
            sink_rdy = !(j == 2 || j == 3 || j == 6);
            src_en[1] = (j != 5);
            step();
            if (hold) begin
                n_vec++;
                if ({o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tvalid} !== held) begin
                    n_err++;
                    $display("FAIL stall_hold cyc=%0d keep=%h valid=%b changed while stalled", j, o_m_tkeep, o_m_tvalid);
                end
            end
            hold = o_m_tvalid && !i_m_tready;
            held = {o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tvalid};
        end
        sink_rdy = 1'b1;
        src_en[1] = 1'b1;
        n_vec++;
        if (acc_src.size() != 6 || obs_q.size() != 6) begin
            n_err++;
            $display("FAIL stall_count acc=%0d obs=%0d want 6", acc_src.size(), obs_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (acc_src[i] != want[i]) begin
                    n_err++;
                    $display("FAIL stall_order idx=%0d got=%0d want %0d", i, acc_src[i], want[i]);
                end
            end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ob = obs_q.pop_front(); eb = exp_q.pop_front();
            n_vec++;
            if (ob !== eb) begin
                n_err++;
                $display("FAIL stall_beat tid=%0d/%0d last=%b/%b keep=%h/%h", ob.tid, eb.tid, ob.last, eb.last, ob.keep, eb.keep);
            end
        end
`ifdef AXIS_CRC_ARB_STATS_EN
        n_vec++;
        if (done_src.size() != 2 || done_src[0] != 1 || done_bytes[0] != 3*KB + 2 ||
            done_src[1] != 3 || done_bytes[1] != 2*KB) begin
            n_err++;
            $display("FAIL stall_stats n=%0d want 2 packets (1:%0d, 3:%0d)", done_src.size(), 3*KB + 2, 2*KB);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int t0;
        beat_t ob, eb;
        do_reset();
        for (int i = 0; i < 6; i++) src_q[0].push_back(mk_beat('1, i == 5));
        for (int k = 0; k < 10 && acc_src.size() < 2; k++) step();
        src_q[0].delete();
        rst_drv = 1'b0;
        step();
        rst_drv = 1'b1;
        step();
        n_vec++;
        if (o_s_tready !== '0 || o_m_tvalid !== 1'b0 || o_m_tlast !== 1'b0 ||
            o_m_tdata !== '0 || o_m_tkeep !== '0 || o_m_tid !== '0 ||
            o_pkt_done !== 1'b0 || o_pkt_src !== '0 || o_pkt_bytes !== '0) begin
            n_err++;
            $display("FAIL midreset_flush valid=%b tready=%b keep=%h want all 0", o_m_tvalid, o_s_tready, o_m_tkeep);
        end
        clear_logs();
        src_q[1].push_back(mk_beat(64'hFF, 1'b0));
        src_q[1].push_back(mk_beat(64'h1, 1'b1));
        t0 = cyc + 1;
        for (int k = 0; k < 20 && obs_q.size() < 2; k++) step();
        n_vec++;
        if (acc_src.size() != 2 || acc_src[0] != 1 || acc_cyc[0] != t0 + 1) begin
            n_err++;
            $display("FAIL midreset_regrant n=%0d want src1 at %0d", acc_src.size(), t0 + 1);
        end
        n_vec++;
        if (obs_q.size() != 2) begin
            n_err++;
            $display("FAIL midreset_count got=%0d want 2", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ob = obs_q.pop_front(); eb = exp_q.pop_front();
            n_vec++;
            if (ob !== eb) begin
                n_err++;
                $display("FAIL midreset_beat tid=%0d/%0d keep=%h/%h", ob.tid, eb.tid, ob.keep, eb.keep);
            end
        end
    endtask

    task automatic test_saturation();
        int bad;
        beat_t ob, eb;
        do_reset();
        for (int i = 0; i < 70; i++) src_q[2].push_back(mk_beat('1, i == 69));
        for (int k = 0; k < 120 && obs_q.size() < 70; k++) step();
        n_vec++;
        if (obs_q.size() != 70) begin
            n_err++;
            $display("FAIL sat_count got=%0d want 70", obs_q.size());
        end
        bad = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ob = obs_q.pop_front(); eb = exp_q.pop_front();
            if (ob !== eb) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL sat_beats bad=%0d want 0", bad);
        end
`ifdef AXIS_CRC_ARB_STATS_EN
        n_vec++;
        if (done_bytes.size() != 1 || done_bytes[0] != 4095) begin
            n_err++;
            $display("FAIL sat_bytes n=%0d bytes=%0d want 4095", done_bytes.size(),
                     done_bytes.size() > 0 ? done_bytes[0] : -1);
        end
`else
        n_vec++;
        if (o_pkt_bytes !== '0 || done_total != 0) begin
            n_err++;
            $display("FAIL nostats_ports bytes=%0d done=%0d want 0", o_pkt_bytes, done_total);
        end
`endif
    endtask

    initial begin
        for (int s = 0; s < NS; s++) src_en[s] = 1'b1;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_stream_crc_arbiter.md
# axi_stream_crc_arbiter

Packet-level round-robin arbiter that shares one downstream AXI-Stream CRC sideband engine between NUM_SRC AXI-Stream sources. Locks a grant for a whole packet, through tlast, and forwards beats through one registered output stage tagged with the source ID. It also accumulates the per-packet byte count from tkeep so the CRC stage and host status logic get a length without recounting. Sits directly upstream of the CRC sideband block in the transmit path.

## Interface
- NUM_SRC, 4: number of requesting sources, 2..16
- DATA_WIDTH, 512: tdata width per source
- KEEP_BYTES, DATA_WIDTH/8: tkeep width per source
- LEN_WIDTH, 16: packet byte-count width
- SRC_W, $clog2(NUM_SRC): source ID width; local, derived
- clk  in  1  single clock; all logic is rising-edge
- srst_n  in  1  synchronous, active-low reset
- i_s_tdata  in  NUM_SRC*DATA_WIDTH  source n at slice [n*DATA_WIDTH +: DATA_WIDTH]
- i_s_tkeep  in  NUM_SRC*KEEP_BYTES  source n at slice [n*KEEP_BYTES +: KEEP_BYTES]
- i_s_tlast  in  NUM_SRC  per-source tlast
- i_s_tvalid  in  NUM_SRC  per-source tvalid
- o_s_tready  out  NUM_SRC  per-source tready; one-hot or zero
- o_m_tdata  out  DATA_WIDTH  granted data, registered
- o_m_tkeep  out  KEEP_BYTES  granted keep, registered
- o_m_tlast  out  1  granted last, registered
- o_m_tid  out  SRC_W  source index of the current output beat
- o_m_tvalid  out  1  output valid
- i_m_tready  in  1  sink ready
- o_pkt_done  out  1  one-cycle pulse per completed packet; only with the stats macro
- o_pkt_src  out  SRC_W  source of the completed packet; only with the stats macro
- o_pkt_bytes  out  LEN_WIDTH  byte length of the completed packet; only with the stats macro

## Operation
- FSM has two states: IDLE and PASS. Reset state is IDLE.
- IDLE:
  - Scan i_s_tvalid from rr_ptr+1 upward, wrapping modulo NUM_SRC. The first asserted source wins.
  - Register the winner in gnt and move to PASS.
  - With no request, stay in IDLE.
- PASS:
  - o_s_tready[gnt] = out_ready; all other tready bits are 0.
  - out_ready = !o_m_tvalid || i_m_tready.
  - A beat is accepted on i_s_tvalid[gnt] && o_s_tready[gnt]. It loads the output register and sets o_m_tid = gnt.
  - On acceptance of a beat with tlast: rr_ptr <= gnt, then go to IDLE.
- Output register: o_m_tvalid clears when i_m_tready is high and no new beat is loaded. Data holds stable while valid && !ready.
- Byte count:
  - Each accepted beat adds popcount(tkeep), range 0..KEEP_BYTES.
  - Non-contiguous keep is counted as-is. An all-zero keep adds 0 and the beat is still forwarded.
  - The accumulator saturates at 2^LEN_WIDTH-1 and clears after a tlast beat.
- A source that drops tvalid mid-packet keeps the grant. There is no timeout.

## Timing
- Reset values:
  - All outputs 0: o_s_tready, o_m_tvalid, o_m_tlast, o_m_tdata, o_m_tkeep, o_m_tid, o_pkt_done, o_pkt_src, o_pkt_bytes.
  - rr_ptr = NUM_SRC-1, so source 0 has first priority.
- Arbitration latency:
  - Request seen in IDLE at cycle t → grant at t+1 → first beat accepted at t+1 at the earliest → o_m_tvalid at t+2.
- Throughput:
  - One beat per cycle within a packet.
  - Exactly one idle input cycle between packets, including back-to-back packets from the same source.
- o_pkt_done pulses the cycle after the tlast beat is accepted at the input. o_pkt_bytes includes the last beat.
- Reset mid-packet: the packet is discarded. The output register is flushed (valid=0) on the next edge, and the FSM returns to IDLE.
- Simultaneous requests: the round-robin order is strict. No source wins twice while another is pending.

## Configuration
- AXIS_CRC_ARB_STATS_EN defined:
  - Byte accumulator and o_pkt_done/o_pkt_src/o_pkt_bytes are built.
- Undefined:
  - Accumulator logic is omitted.
  - The stats ports still exist, tied to 0.
  - Arbitration and data timing are identical in both builds.

## Structure
- Shared package axis_crc_pkg holds:
  - arb_state_t enum (IDLE, PASS)
  - DEFAULT_DATA_WIDTH
  - DEFAULT_LEN_WIDTH
  - popcount function
- Sub-module axis_rr_pick: combinational round-robin picker (req, ptr → gnt, found), instantiated once.

## Test plan
- Reset then a single 3-beat packet on source 2, keep all-ones then 0x0F on the last beat, i_m_tready=1:
  - 3 output beats, o_m_tid=2.
  - o_pkt_bytes = 2*KEEP_BYTES + 4, pulse one cycle after the last beat is accepted.
- All 4 sources request continuously with 1-beat packets:
  - Grant order 0,1,2,3,0,…
  - Exactly one idle cycle between packets.
- Source 1 mid-packet while i_m_tready toggles 1,0,0,1:
  - o_m_tdata/o_m_tkeep/o_m_tlast held stable during stall.
  - No beat lost or duplicated.
  - Source 3 never granted before source 1's tlast.
- srst_n low for 1 cycle in the middle of a source 0 packet:
  - Next cycle all outputs are 0.
  - A subsequent source 1 request is granted from IDLE.
- 70-beat all-ones packet with LEN_WIDTH=12, KEEP_BYTES=64:
  - o_pkt_bytes saturates at 4095.
- Build without AXIS_CRC_ARB_STATS_EN and rerun the round-robin scenario:
  - Identical output beat stream.
  - o_pkt_done never asserts.
